rf_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the pipelined register file. Shares the file's single write port between the in-order writeback stage and the long-latency multiply/divide unit (MDU), buffering MDU results in a small FIFO. Tracks destination registers with an outstanding MDU result and tells decode when to stall. Sits between the WB stage and MDU on one side and the register-file write port and hazard logic on the other.

---
 rtl/rf_arb_pkg.sv | 13 +
 rtl/rf_wb_arbiter_if.sv | 48 ++++
 rtl/rf_wb_fifo.sv | 66 ++++++
 rtl/rf_wb_arbiter.sv | 119 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_arb_pkg.sv
// Shared widths and the register-write payload for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of WB, MDU, issue, decode and register-file write-port signals around the arbiter.
interface rf_wb_arbiter_if;
  import rf_arb_pkg::*;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              mdu_valid;
  logic [REG_AW-1:0] mdu_rd;
  logic [XLEN-1:0]   mdu_data;
  logic              mdu_ready;

  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic              issue_ok;

  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic [REG_AW-1:0] dec_rd;
  logic              dec_stall;
  logic              pipe_hold;

  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wd;

  // Arbiter side
  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  issue_valid, issue_rd,
    input  dec_rs1, dec_rs2, dec_rd,
    output mdu_ready, issue_ok, dec_stall, pipe_hold,
    output rf_we, rf_rd, rf_wd
  );

  // Pipeline / environment side
  modport master (
    output wb_valid, wb_rd, wb_data,
    output mdu_valid, mdu_rd, mdu_data,
    output issue_valid, issue_rd,
    output dec_rs1, dec_rs2, dec_rd,
    input  mdu_ready, issue_ok, dec_stall, pipe_hold,
    input  rf_we, rf_rd, rf_wd
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO buffering MDU register writes until the write port is granted.
module rf_wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  rf_wr_t push_data_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output rf_wr_t head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rf_wr_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO still accepts a push when the head leaves in the same cycle
  always_comb begin
    full_o   = (cnt_q == CNT_W'(DEPTH));
    empty_o  = (cnt_q == '0);
    head_o   = mem_q[rd_ptr_q];
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between WB and buffered MDU results, tracks
// registers awaiting an MDU result, and raises decode stall / pipeline hold.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  rf_wb_arbiter_if.slave bus_if
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);

  rf_wr_t           mdu_wr;
  rf_wr_t           fifo_head;
  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;

  logic             wb_intent;
  logic             hold;
  logic             grant_wb;
  logic             grant_fifo;

  logic [ST_W-1:0]  starve_q, starve_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] outst_q, outst_d;

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (mdu_wr),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Write-port arbitration: a held pipe forces the FIFO head through
  always_comb begin
    mdu_wr.rd   = bus_if.mdu_rd;
    mdu_wr.data = bus_if.mdu_data;
    wb_intent   = bus_if.wb_valid && (bus_if.wb_rd != '0);
    hold        = (starve_q == ST_W'(STARVE_LIMIT));
    grant_fifo  = !fifo_empty && (hold || !wb_intent);
    grant_wb    = !hold && wb_intent;
    fifo_push   = bus_if.mdu_valid && !fifo_full;
    fifo_pop    = grant_fifo;
  end

  // Next-state for starvation counter, scoreboard and outstanding-op count
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || grant_fifo) begin
      starve_d = '0;
    end else if (starve_q != ST_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + ST_W'(1);
    end

    busy_d = busy_q;
    if (grant_fifo) begin
      busy_d[fifo_head.rd] = 1'b0;
    end
    if (bus_if.issue_valid) begin
      busy_d[bus_if.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    outst_d = outst_q;
    if (bus_if.issue_valid && !(grant_fifo && (outst_q != '0))) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (!bus_if.issue_valid && grant_fifo && (outst_q != '0)) begin
      outst_d = outst_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      busy_q   <= '0;
      outst_q  <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
      outst_q  <= outst_d;
    end
  end

  // An x0 MDU result consumes its grant without enabling the write
  always_comb begin
    bus_if.rf_we     = 1'b0;
    bus_if.rf_rd     = '0;
    bus_if.rf_wd     = '0;
    if (grant_wb) begin
      bus_if.rf_we = 1'b1;
      bus_if.rf_rd = bus_if.wb_rd;
      bus_if.rf_wd = bus_if.wb_data;
    end else if (grant_fifo && (fifo_head.rd != '0)) begin
      bus_if.rf_we = 1'b1;
      bus_if.rf_rd = fifo_head.rd;
      bus_if.rf_wd = fifo_head.data;
    end
    bus_if.mdu_ready = !fifo_full;
    bus_if.issue_ok  = (outst_q < CNT_W'(DEPTH));
    bus_if.pipe_hold = hold;
    bus_if.dec_stall = busy_q[bus_if.dec_rs1] | busy_q[bus_if.dec_rs2] |
                       busy_q[bus_if.dec_rd] | hold;
  end

  issue_within_capacity: assert property (
    @(posedge clk) disable iff (reset) !(bus_if.issue_valid && !bus_if.issue_ok)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench: expected register writes are queued by the stimulus and checked by a monitor.
module tb_rf_wb_arbiter;
  import rf_arb_pkg::*;

  typedef struct {
    int                cyc;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } exp_wr_t;

  logic    clk = 1'b0;
  logic    reset;
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  bit      mon_en = 1'b0;
  exp_wr_t exp_q[$];
  exp_wr_t mon_e;

  rf_wb_arbiter_if bus_if();

  rf_wb_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic st(input string tag, input logic hold, input logic stall,
                    input logic ready, input logic ok);
    chk({tag, "_pipe_hold"}, 32'(bus_if.pipe_hold), 32'(hold));
    chk({tag, "_dec_stall"}, 32'(bus_if.dec_stall), 32'(stall));
    chk({tag, "_mdu_ready"}, 32'(bus_if.mdu_ready), 32'(ready));
    chk({tag, "_issue_ok"},  32'(bus_if.issue_ok),  32'(ok));
  endtask

  task automatic exp_wr(input int c, input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
    exp_wr_t e;
    e.cyc  = c;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus_if.wb_valid    = 1'b0;
    bus_if.wb_rd       = '0;
    bus_if.wb_data     = '0;
    bus_if.mdu_valid   = 1'b0;
    bus_if.mdu_rd      = '0;
    bus_if.mdu_data    = '0;
    bus_if.issue_valid = 1'b0;
    bus_if.issue_rd    = '0;
    bus_if.dec_rs1     = '0;
    bus_if.dec_rs2     = '0;
    bus_if.dec_rd      = '0;
  endtask

  task automatic wb(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
    bus_if.wb_valid = 1'b1;
    bus_if.wb_rd    = rd;
    bus_if.wb_data  = d;
  endtask

  task automatic mdu(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
    bus_if.mdu_valid = 1'b1;
    bus_if.mdu_rd    = rd;
    bus_if.mdu_data  = d;
  endtask

  task automatic issue(input logic [REG_AW-1:0] rd);
    bus_if.issue_valid = 1'b1;
    bus_if.issue_rd    = rd;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Monitor: every write-port cycle is matched against the expected-write queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_if.rf_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write at cycle %0d: got rd=%0d data=0x%0h, expected no write",
                   cyc, bus_if.rf_rd, bus_if.rf_wd);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("wr_rd",    32'(bus_if.rf_rd), 32'(mon_e.rd));
          chk("wr_data",  bus_if.rf_wd, mon_e.data);
        end
      end else begin
        chk("idle_rf_rd", 32'(bus_if.rf_rd), 32'd0);
        chk("idle_rf_wd", bus_if.rf_wd, 32'd0);
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          mon_e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_write at cycle %0d: got no write, expected rd=%0d data=0x%0h",
                   cyc, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    bus_if.dec_rs1 = 5'd5;
    neg();
    st("reset", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("reset_rf_we", 32'(bus_if.rf_we), 32'd0);
    go();
    idle();

    // Idle drain: x5 written one cycle after enqueue, stall drops a cycle later
    issue(5'd5); neg(); go();
    bus_if.issue_valid = 1'b0; bus_if.dec_rs1 = 5'd5;
    mdu(5'd5, 32'h1234); exp_wr(cyc + 1, 5'd5, 32'h1234);
    neg(); st("drain_enq", 1'b0, 1'b1, 1'b1, 1'b1); go();
    bus_if.mdu_valid = 1'b0;
    neg(); st("drain_wr", 1'b0, 1'b1, 1'b1, 1'b1); go();
    neg(); st("drain_clr", 1'b0, 1'b0, 1'b1, 1'b1); go();
    idle(); go();

    // WB priority: four WB wins, one held cycle for x7, then WB repeats
    issue(5'd7); neg(); go();
    bus_if.issue_valid = 1'b0; bus_if.dec_rd = 5'd7;
    mdu(5'd7, 32'h77);
    neg(); st("wbp_enq", 1'b0, 1'b1, 1'b1, 1'b1); go();
    bus_if.mdu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb(5'd3, 32'h300 + i); exp_wr(cyc, 5'd3, 32'h300 + i);
      neg(); st("wbp_win", 1'b0, 1'b1, 1'b1, 1'b1); go();
    end
    wb(5'd3, 32'h304); exp_wr(cyc, 5'd7, 32'h77);
    neg(); st("wbp_hold", 1'b1, 1'b1, 1'b1, 1'b1); go();
    exp_wr(cyc, 5'd3, 32'h304);
    neg(); st("wbp_after", 1'b0, 1'b0, 1'b1, 1'b1); go();
    idle(); go();

    // WB to x0 yields the slot; an x0 MDU result drains without a write
    issue(5'd9); neg(); go();
    bus_if.issue_valid = 1'b0;
    mdu(5'd9, 32'h99); neg(); go();
    bus_if.mdu_valid = 1'b0; bus_if.dec_rs1 = 5'd9;
    wb(5'd0, 32'hDEAD); exp_wr(cyc, 5'd9, 32'h99);
    neg(); st("x0_wb", 1'b0, 1'b1, 1'b1, 1'b1); go();
    idle(); bus_if.dec_rs1 = 5'd9; issue(5'd0);
    neg(); st("x0_clr", 1'b0, 1'b0, 1'b1, 1'b1); go();
    bus_if.issue_valid = 1'b0; bus_if.dec_rd = 5'd0;
    mdu(5'd0, 32'hBAD);
    neg(); st("x0_mdu", 1'b0, 1'b0, 1'b1, 1'b1); go();
    bus_if.mdu_valid = 1'b0;
    neg(); st("x0_nop", 1'b0, 1'b0, 1'b1, 1'b1); go();
    idle(); go();

    // RAW on rs2, WAW on rd, and set-wins when reissuing during the clearing write
    issue(5'd10); neg(); go();
    bus_if.issue_valid = 1'b0; bus_if.dec_rs2 = 5'd10;
    neg(); st("raw_wait", 1'b0, 1'b1, 1'b1, 1'b1); go();
    mdu(5'd10, 32'hA0); exp_wr(cyc + 1, 5'd10, 32'hA0);
    neg(); st("raw_enq", 1'b0, 1'b1, 1'b1, 1'b1); go();
    bus_if.mdu_valid = 1'b0;
    neg(); st("raw_wr", 1'b0, 1'b1, 1'b1, 1'b1); go();
    neg(); st("raw_clr", 1'b0, 1'b0, 1'b1, 1'b1); go();
    idle(); bus_if.dec_rd = 5'd10; issue(5'd10);
    neg(); st("waw_issue", 1'b0, 1'b0, 1'b1, 1'b1); go();
    bus_if.issue_valid = 1'b0;
    mdu(5'd10, 32'hA1); exp_wr(cyc + 1, 5'd10, 32'hA1);
    neg(); st("waw_enq", 1'b0, 1'b1, 1'b1, 1'b1); go();
    bus_if.mdu_valid = 1'b0; issue(5'd10);
    neg(); st("waw_wr", 1'b0, 1'b1, 1'b1, 1'b1); go();
    bus_if.issue_valid = 1'b0;
    mdu(5'd10, 32'hA2); exp_wr(cyc + 1, 5'd10, 32'hA2);
    neg(); st("setwins", 1'b0, 1'b1, 1'b1, 1'b1); go();
    bus_if.mdu_valid = 1'b0;
    neg(); st("setwins_wr", 1'b0, 1'b1, 1'b1, 1'b1); go();
    neg(); st("setwins_clr", 1'b0, 1'b0, 1'b1, 1'b1); go();
    idle(); go();

    // Capacity: two ops fill the count, two results fill the FIFO under WB traffic
    issue(5'd1); neg(); st("cap_i1", 1'b0, 1'b0, 1'b1, 1'b1); go();
    issue(5'd2); neg(); st("cap_i2", 1'b0, 1'b0, 1'b1, 1'b1); go();
    bus_if.issue_valid = 1'b0;
    wb(5'd4, 32'h400); exp_wr(cyc, 5'd4, 32'h400); mdu(5'd1, 32'h11);
    neg(); st("cap_full_cnt", 1'b0, 1'b0, 1'b1, 1'b0); go();
    wb(5'd4, 32'h401); exp_wr(cyc, 5'd4, 32'h401); mdu(5'd2, 32'h22);
    neg(); st("cap_push2", 1'b0, 1'b0, 1'b1, 1'b0); go();
    bus_if.mdu_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      wb(5'd4, 32'h400 + i); exp_wr(cyc, 5'd4, 32'h400 + i);
      neg(); st("cap_fifo_full", 1'b0, 1'b0, 1'b0, 1'b0); go();
    end
    wb(5'd4, 32'h405); exp_wr(cyc, 5'd1, 32'h11);
    neg(); st("cap_hold", 1'b1, 1'b1, 1'b0, 1'b0); go();
    exp_wr(cyc, 5'd4, 32'h405);
    neg(); st("cap_wb_retry", 1'b0, 1'b0, 1'b1, 1'b1); go();
    bus_if.wb_valid = 1'b0; exp_wr(cyc, 5'd2, 32'h22);
    neg(); st("cap_drain2", 1'b0, 1'b0, 1'b1, 1'b1); go();
    neg(); st("cap_empty", 1'b0, 1'b0, 1'b1, 1'b1); go();
    idle(); go();

    // Reset with two queued results and x5/x10 busy
    issue(5'd5); neg(); go();
    issue(5'd10); neg(); go();
    bus_if.issue_valid = 1'b0; bus_if.dec_rs1 = 5'd5; bus_if.dec_rs2 = 5'd10;
    wb(5'd4, 32'h500); exp_wr(cyc, 5'd4, 32'h500); mdu(5'd5, 32'h55);
    neg(); st("rst_pre1", 1'b0, 1'b1, 1'b1, 1'b0); go();
    wb(5'd4, 32'h501); exp_wr(cyc, 5'd4, 32'h501); mdu(5'd10, 32'hAA);
    neg(); st("rst_pre2", 1'b0, 1'b1, 1'b1, 1'b0); go();
    bus_if.mdu_valid = 1'b0;
    wb(5'd4, 32'h502); exp_wr(cyc, 5'd4, 32'h502); reset = 1'b1;
    neg(); st("rst_assert", 1'b0, 1'b1, 1'b0, 1'b0); go();
    reset = 1'b0; idle(); bus_if.dec_rs1 = 5'd5; bus_if.dec_rs2 = 5'd10;
    neg(); st("rst_after", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_rf_we", 32'(bus_if.rf_we), 32'd0);
    chk("rst_rf_rd", 32'(bus_if.rf_rd), 32'd0);
    chk("rst_rf_wd", bus_if.rf_wd, 32'd0);
    go();
    neg(); st("rst_settled", 1'b0, 1'b0, 1'b1, 1'b1); go();
    idle();
    repeat (3) go();

    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
